// File: rtl/pulse_sequencer.sv
// pulse_sequencer: programmable on/off waveform generator with a repeat count.
// A host starts a run with start; busy covers the ON/OFF phases and done
// pulses for one cycle when all periods have completed. abort cancels a run
// without a done pulse.
module pulse_sequencer #(
  parameter int CNT_W = 20,
  parameter int REP_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] on_len,
  input  logic [CNT_W-1:0] off_len,
  input  logic [REP_W-1:0] reps,
  input  logic             abort,
  output logic             out,
  output logic             busy,
  output logic             done,
  output logic [REP_W-1:0] rep_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ON,
    S_OFF,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] on_len_q, on_len_d;
  logic [CNT_W-1:0] off_len_q, off_len_d;
  logic [REP_W-1:0] reps_q, reps_d;
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             out_q, out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [REP_W-1:0] rep_inc;
  logic             last_rep;

  // Next-state, counter and registered-output computation.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    on_len_d  = on_len_q;
    off_len_d = off_len_q;
    reps_d    = reps_q;
    rep_cnt_d = rep_cnt_q;
    // rep_cnt never exceeds reps-1 while a period is running, so this
    // increment cannot overflow even when reps is all ones.
    rep_inc   = rep_cnt_q + REP_W'(1);
    last_rep  = (rep_inc == reps_q);

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          on_len_d  = on_len;
          off_len_d = off_len;
          reps_d    = reps;
          rep_cnt_d = '0;
          cnt_d     = '0;
          if (on_len == '0 || reps == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ON;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      S_ON: begin
        if (cnt_q == on_len_q) begin
          cnt_d = CNT_W'(1);
          if (off_len_q != '0) begin
            state_d = S_OFF;
          end else begin
            // No low phase: the period ends here and ON restarts seamlessly.
            rep_cnt_d = rep_inc;
            if (last_rep) begin
              state_d = S_DONE;
              cnt_d   = '0;
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_OFF: begin
        if (cnt_q == off_len_q) begin
          rep_cnt_d = rep_inc;
          cnt_d     = CNT_W'(1);
          if (last_rep) begin
            state_d = S_DONE;
            cnt_d   = '0;
          end else begin
            state_d = S_ON;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        // start is deliberately ignored here; the earliest accepted start is
        // sampled on the edge after done drops.
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // abort overrides everything, including a coincident start in IDLE:
    // the latched config and rep_cnt keep their previous values.
    if (abort) begin
      state_d   = S_IDLE;
      cnt_d     = '0;
      on_len_d  = on_len_q;
      off_len_d = off_len_q;
      reps_d    = reps_q;
      rep_cnt_d = rep_cnt_q;
    end

    out_d  = (state_d == S_ON);
    busy_d = (state_d == S_ON) || (state_d == S_OFF);
    done_d = (state_d == S_DONE);
  end

  // State, counters, latched config and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      on_len_q  <= '0;
      off_len_q <= '0;
      reps_q    <= '0;
      rep_cnt_q <= '0;
      out_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      on_len_q  <= on_len_d;
      off_len_q <= off_len_d;
      reps_q    <= reps_d;
      rep_cnt_q <= rep_cnt_d;
      out_q     <= out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign out     = out_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign rep_cnt = rep_cnt_q;

endmodule

// File: doc/pulse_sequencer.md
# pulse_sequencer

Programmable on/off waveform controller. It drives a single-bit `out` through a repeated high/low pattern with run-time on-length, off-length and repeat count. It replaces the free-running output generator that the cycle-counting benches observe today. It sits between a host or control FSM, which uses a start/busy/done handshake, and any downstream block that consumes a timed enable or pulse train.

## Interface
- `CNT_W`, default 20: width of on/off length fields. Covers at least 310000 cycles.
- `REP_W`, default 8: width of repeat count.
- `clk`  input  1  single clock; all state updates on rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  request; sampled only in IDLE.
- `on_len`  input  CNT_W  high-phase length in cycles; latched on accepted start.
- `off_len`  input  CNT_W  low-phase length in cycles; latched on accepted start.
- `reps`  input  REP_W  number of on/off periods; latched on accepted start.
- `abort`  input  1  synchronous cancel; highest priority after reset.
- `out`  output  1  generated waveform, registered.
- `busy`  output  1  high in ON/OFF states.
- `done`  output  1  one-cycle completion pulse.
- `rep_cnt`  output  REP_W  number of completed periods in the current run.

## Operation
- States: IDLE, ON, OFF, DONE. Encoding is free. All outputs are registered or decoded from state only.
- Reset (`rst_n`=0, asynchronous):
  - state=IDLE.
  - `out`=0, `busy`=0, `done`=0, `rep_cnt`=0.
  - Phase counter=0.
  - Latched config=0.
- IDLE:
  - On `start`=1, latch `on_len`, `off_len`, `reps`, clear `rep_cnt` and the phase counter.
  - If latched `on_len`==0 or `reps`==0, go to DONE. `out` stays 0.
  - Otherwise go to ON.
- ON:
  - `out`=1.
  - The phase counter counts 1..`on_len`.
  - On the last cycle, if `off_len`≠0, go to OFF.
  - If `off_len`==0, the period is complete: increment `rep_cnt`, then go to DONE if `rep_cnt`+1==`reps`, else restart ON with the counter reset. `out` stays 1 with no gap.
- OFF:
  - `out`=0.
  - The phase counter counts 1..`off_len`.
  - On the last cycle, increment `rep_cnt`, then go to DONE if `rep_cnt`+1==`reps`, else go to ON.
- DONE: `done`=1, `out`=0, `busy`=0 for exactly one cycle, then go to IDLE. `rep_cnt` holds its final value until the next accepted start.
- `start` outside IDLE is ignored, including in DONE. No queuing.
- `abort`=1 in any state:
  - Next state is IDLE, with `out`=0 and `busy`=0.
  - No `done` pulse.
  - `rep_cnt` holds its value.
  - `abort` and `start` together in IDLE: abort wins and start is dropped.
- Config inputs may change freely while busy. Only the values latched at start are used.
- Arithmetic:
  - The phase counter is CNT_W bits and is compared against the latched length. It never wraps, because lengths ≤ 2^CNT_W−1.
  - `rep_cnt` is REP_W bits. `reps`=2^REP_W−1 completes without overflow.

## Timing
- E0 is the rising edge that samples `start`=1 in IDLE.
- Nonzero lengths:
  - `out` rises after E0 and falls after E0+`on_len`.
  - The period is `on_len`+`off_len` cycles.
  - `done` is high in the cycle after edge E0+`reps`·(`on_len`+`off_len`).
  - `busy` is high from E0 until that same edge.
- Zero `on_len` or `reps`: `done` is high in the cycle after E0, and `busy` never asserts.
- `rep_cnt` increments on the edge ending each OFF phase, or each ON phase when `off_len`==0.
- Latency:
  - `start` to first `out` high: 1 edge.
  - Final phase end to `done`: 0 extra cycles.
  - `done` to next accepted start: earliest start can be sampled on the edge after `done` deasserts.
- `abort` sampled at edge Ea: `out`=0 and `busy`=0 after Ea.
- Mid-operation asynchronous reset clears all outputs immediately, without waiting for a clock edge.

## Test plan
- `on_len`=5, `off_len`=5, `reps`=3:
  - `out` high cycles 1–5, 11–15, 21–25 after E0.
  - `rep_cnt` steps 1,2,3.
  - `done` pulses at cycle 31, with `busy` low thereafter.
- `on_len`=4, `off_len`=0, `reps`=2: `out` high for 8 contiguous cycles, then `done` at cycle 9.
- `on_len`=0, `reps`=7: `done` at cycle 1, `out` never high, `busy` never high, `rep_cnt`=0.
- `on_len`=3, `off_len`=2, `reps`=4 with `start` re-pulsed at cycle 4 and config changed to `on_len`=9: second start ignored, and the original waveform completes with `done` at cycle 21.
- `on_len`=10, `off_len`=10, `reps`=5:
  - `abort` at cycle 12: `out`=0, `busy`=0 next cycle, no `done`, `rep_cnt`=0.
  - `rst_n` low at cycle 27 of a fresh run (asynchronously, mid-cycle): all outputs 0 before the next edge.
- Maximum values: `on_len`=310000, `off_len`=1, `reps`=1 → `out` high exactly 310000 cycles, `done` at cycle 310002.
